// File: rtl/fp_regfile.sv
// Coprocessor-1 floating-point register file: 32 x 32-bit FPRs,
// single/pair reads, FPU and mem write ports, sticky error flags.
module fp_regfile #(
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  fs_addr,
  input  logic [4:0]  ft_addr,
  input  logic        rd_double,
  output logic [31:0] rd0_0,
  output logic [31:0] rd0_1,
  output logic [31:0] rd1_0,
  output logic [31:0] rd1_1,
  input  logic        fpu_we,
  input  logic [4:0]  fpu_waddr,
  input  logic        fpu_wdouble,
  input  logic [31:0] fpu_wdata_0,
  input  logic [31:0] fpu_wdata_1,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        err_clr,
  output logic        err_align,
  output logic        err_conflict
);

  logic [31:0] fpr [32];
  logic [31:0] fpu_hit;
  logic [31:0] mem_hit;
  logic        conflict;
  logic        misalign;

  logic [4:0] fs_hi, fs_lo;
  logic [4:0] ft_hi, ft_lo;

  always_comb begin
    fpu_hit = '0;
    mem_hit = '0;
    for (int i = 0; i < 32; i++) begin
      if (fpu_we) begin
        if (fpu_wdouble)
          fpu_hit[i] = (fpu_waddr[4:1] == 4'(i >> 1));
        else
          fpu_hit[i] = (fpu_waddr == 5'(i));
      end
      mem_hit[i] = mem_we & (mem_waddr == 5'(i));
    end
  end

  assign conflict = |(fpu_hit & mem_hit);
  assign misalign =
    (rd_double & (fs_addr[0] | ft_addr[0])) |
    (fpu_we & fpu_wdouble & fpu_waddr[0]);

  // Mem port wins any register both ports target.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!rst_n) begin
        if (ZERO_ON_RESET)
          fpr[i] <= '0;
      end else if (mem_hit[i]) begin
        fpr[i] <= mem_wdata;
      end else if (fpu_hit[i]) begin
        if (fpu_wdouble && (i % 2 == 0))
          fpr[i] <= fpu_wdata_1;
        else
          fpr[i] <= fpu_wdata_0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_align    <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      err_align    <= misalign | (err_align & ~err_clr);
      err_conflict <= conflict | (err_conflict & ~err_clr);
    end
  end

  always_comb begin
    fs_hi = fs_addr | 5'd1;
    ft_hi = ft_addr | 5'd1;
    fs_lo = fs_addr;
    ft_lo = ft_addr;
    if (rd_double) begin
      fs_lo = {fs_addr[4:1], 1'b0};
      ft_lo = {ft_addr[4:1], 1'b0};
    end
  end

  // Single read: _0 is the word, _1 its odd partner.
  assign rd0_0 = rd_double ? fpr[fs_hi] : fpr[fs_lo];
  assign rd0_1 = rd_double ? fpr[fs_lo] : fpr[fs_hi];
  assign rd1_0 = rd_double ? fpr[ft_hi] : fpr[ft_lo];
  assign rd1_1 = rd_double ? fpr[ft_lo] : fpr[ft_hi];

endmodule

// File: doc/fp_regfile.md
# fp_regfile

Coprocessor-1 floating-point register file: 32 × 32-bit FPRs feeding the FP ALU's two operand pairs and accepting its writeback. It sits directly upstream of the FP ALU and also closes the loop from it. Reads deliver either a single word or an even/odd register pair, so double-precision operands arrive high word first. Writes come from the FP ALU result path (single or double) and from the integer/memory path (mtc1/lwc1, single word only). A sticky error register flags misaligned double accesses and same-cycle write conflicts.

## Interface
- ZERO_ON_RESET, 1: when 1, all 32 FPRs are cleared on reset; when 0, only the error flags are reset.
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- fs_addr  in  5  read address, operand 0
- ft_addr  in  5  read address, operand 1
- rd_double  in  1  1 = read register pairs for both operands
- rd0_0 / rd0_1  out  32 / 32  operand 0: high word / low word
- rd1_0 / rd1_1  out  32 / 32  operand 1: high word / low word
- fpu_we  in  1  FP ALU writeback enable
- fpu_waddr  in  5  FP writeback register
- fpu_wdouble  in  1  1 = write a pair
- fpu_wdata_0 / fpu_wdata_1  in  32 / 32  FP result high word / low word
- mem_we  in  1  integer/memory-side write enable (mtc1/lwc1)
- mem_waddr  in  5  target FPR
- mem_wdata  in  32  write data
- err_clr  in  1  clears the sticky error flags
- err_align  out  1  sticky: a double access used an odd address
- err_conflict  out  1  sticky: both write ports hit the same FPR in one cycle

## Operation
- **Pair mapping.** Double register n uses base b = n & 5'b11110. The high word is FPR[b+1] and the low word is FPR[b].
- **Single read.** rdX_0 = FPR[addr]. rdX_1 = FPR[addr | 1], which is don't-care for the consumer but deterministic.
- **Double read.** rdX_0 = FPR[b+1], rdX_1 = FPR[b].
- **Reads are combinational** from the stored array. There is no write-to-read bypass: a write becomes visible after the clock edge.
- **FPU single write.** FPR[fpu_waddr] <= fpu_wdata_0.
- **FPU double write.** FPR[b+1] <= fpu_wdata_0 and FPR[b] <= fpu_wdata_1, using b from fpu_waddr.
- **Mem write.** FPR[mem_waddr] <= mem_wdata.
- **Conflict.** A conflict exists when both enables are high and mem_waddr falls in the set of FPRs the FPU write targets (one register, or the pair).
  - On a conflict, the mem port wins for the overlapping register.
  - Non-overlapping registers of an FPU double write are still written.
  - err_conflict is set.
- **err_align** is set on any edge where:
  - rd_double=1 and fs_addr[0] or ft_addr[0] is 1, or
  - fpu_we & fpu_wdouble & fpu_waddr[0].
- **Misaligned accesses still proceed** using the aligned base b.
- **Error flags.** Both are sticky. err_clr clears them on the next edge. If a set condition and err_clr occur in the same cycle, set wins.

## Timing
- **Reset.** Both error flags go to 0. If ZERO_ON_RESET=1, every FPR goes to 0, so all rd outputs read 0 in the first cycle after reset.
- **Reset overrides writes.** Writes presented during a reset cycle are discarded.
- **Write latency** is 1 cycle: data written at edge k is visible on the read outputs from cycle k onward (combinational after the edge).
- **Read latency** is 0 cycles, combinational from the address inputs.
- **Single-cycle datapath.** A read and a write to the same FPR in the same cycle returns the OLD value; the new value appears after the edge.
- **Error flag timing.** The flags are registered and rise one edge after the triggering condition.

## Test plan
- **Reset and basic write/read.** Reset with ZERO_ON_RESET=1 and read all 32 addresses → all 0, err_* = 0. Then mem write FPR[3]=32'h3F800000 and read fs=3 single → rd0_0 = 3F800000 next cycle.
- **Double write and read.** fpu_wdouble, waddr=6, wdata_0=0x40090000, wdata_1=0x00000001 → FPR[7]=40090000, FPR[6]=00000001. A double read with fs=6 → rd0_0=40090000, rd0_1=00000001.
- **Same-cycle read of written register.** Write FPR[2]=AAAA_AAAA while fs_addr=2 → rd0_0 shows the old value in that cycle and AAAA_AAAA after the edge.
- **Write conflict.** fpu double write to 8 and mem write to 9 (data 0x12345678) in the same cycle → FPR[9]=12345678, FPR[8]=fpu_wdata_1, err_conflict=1 the next cycle.
- **Misaligned double read.** rd_double=1, ft_addr=5 → reads pair 4/5, err_align=1 after the edge. Then err_clr with no new violation → 0 next cycle. err_clr together with a fresh violation → stays 1.
- **Reset mid-operation.** Pulse rst_n low during an active fpu_we → that write is discarded and all FPRs read 0.
